// File: rtl/dcm_pkg.sv
// Shared types and default constants for the DCM reset sequencer.
// Holds the FSM state encoding and the default timing/retry values.
package dcm_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } dcm_state_t;

    // 100 us of good lock at 50 MHz
    localparam int DEF_LOCK_STABLE_CYC = 5000;
    localparam int DEF_STAGGER_CYC     = 50;
    localparam int DEF_MAX_RETRY       = 8;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser with asynchronous active-high reset.
// Ports: clk, rst, d_i (async input), q_o (synchronised, 2 cycles late).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/dcm_rst_seq.sv
// DCM-lock driven reset sequencer: waits for a stable lock, then releases
// NUM_DOM domain resets in staggered order, counting retries and lock losses.
// Ports: clk, rst (async, high), dcm_lock/dcm_sta2/dcm_rst (async inputs),
// sys_rst (per-domain reset, bit 0 first), rst_done, dcm_fail (sticky),
// retry_cnt (DCM reset pulses since RUN), lock_loss_cnt (saturating).
module dcm_rst_seq
    import dcm_pkg::*;
#(
    parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int STAGGER_CYC     = DEF_STAGGER_CYC,
    parameter int NUM_DOM         = 4,
    parameter int MAX_RETRY       = DEF_MAX_RETRY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dcm_lock,
    input  logic               dcm_sta2,
    input  logic               dcm_rst,
    output logic [NUM_DOM-1:0] sys_rst,
    output logic               rst_done,
    output logic               dcm_fail,
    output logic [3:0]         retry_cnt,
    output logic [7:0]         lock_loss_cnt
);

    localparam int SCW = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
    localparam int GCW = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
    localparam int DIW = $clog2(NUM_DOM + 1);

    localparam logic [SCW-1:0] STB_LAST = SCW'(LOCK_STABLE_CYC - 1);
    localparam logic [GCW-1:0] STG_LAST = GCW'(STAGGER_CYC - 1);
    localparam logic [DIW-1:0] DOM_ALL  = DIW'(NUM_DOM);
    localparam logic [3:0]     RTY_MAX  = 4'(MAX_RETRY);

    dcm_state_t         state_q, state_d;
    logic [SCW-1:0]     stb_q, stb_d;
    logic [GCW-1:0]     stg_q, stg_d;
    logic [DIW-1:0]     dom_q, dom_d;
    logic [NUM_DOM-1:0] sys_rst_q, sys_rst_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic [3:0]         retry_q, retry_d;
    logic [7:0]         loss_q, loss_d;
    logic               drst_prev_q;

    logic lock_s;
    logic sta2_s;
    logic drst_s;
    logic good;
    logic retry_inc;

    sync_2ff u_sync_lock (
        .clk (clk),
        .rst (rst),
        .d_i (dcm_lock),
        .q_o (lock_s)
    );

    sync_2ff u_sync_sta2 (
        .clk (clk),
        .rst (rst),
        .d_i (dcm_sta2),
        .q_o (sta2_s)
    );

    sync_2ff u_sync_drst (
        .clk (clk),
        .rst (rst),
        .d_i (dcm_rst),
        .q_o (drst_s)
    );

    assign good      = lock_s & ~sta2_s;
    assign retry_inc = drst_s & ~drst_prev_q
                     & (state_q != RUN) & (state_q != FAIL);

    always_comb begin
        state_d   = state_q;
        stb_d     = stb_q;
        stg_d     = stg_q;
        dom_d     = dom_q;
        sys_rst_d = sys_rst_q;
        done_d    = done_q;
        fail_d    = fail_q;
        loss_d    = loss_q;
        retry_d   = retry_q + 4'(retry_inc);

        unique case (state_q)
            WAIT_LOCK: begin
                stb_d = '0;
                if (good) state_d = STABLE;
            end
            STABLE: begin
                if (!good) begin
                    state_d = WAIT_LOCK;
                end else if (stb_q == STB_LAST) begin
                    // domain 0 is released on RELEASE entry
                    state_d   = RELEASE;
                    sys_rst_d = ~NUM_DOM'(1);
                    dom_d     = DIW'(1);
                    stg_d     = '0;
                end else begin
                    stb_d = stb_q + 1'b1;
                end
            end
            RELEASE, RUN: begin
                if (!good) begin
                    state_d   = WAIT_LOCK;
                    sys_rst_d = '1;
                    done_d    = 1'b0;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end else if (state_q == RELEASE) begin
                    if (dom_q == DOM_ALL) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                        retry_d = '0;
                    end else if (stg_q == STG_LAST) begin
                        sys_rst_d = sys_rst_q & ~(NUM_DOM'(1) << dom_q);
                        dom_d     = dom_q + 1'b1;
                        stg_d     = '0;
                    end else begin
                        stg_d = stg_q + 1'b1;
                    end
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d   = WAIT_LOCK;
                sys_rst_d = '1;
                done_d    = 1'b0;
            end
        endcase

        // retry exhaustion overrides every other transition
        if (retry_inc && (retry_q + 4'd1 == RTY_MAX)) begin
            state_d   = FAIL;
            sys_rst_d = '1;
            done_d    = 1'b0;
            fail_d    = 1'b1;
            retry_d   = RTY_MAX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_LOCK;
            stb_q       <= '0;
            stg_q       <= '0;
            dom_q       <= '0;
            sys_rst_q   <= '1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            retry_q     <= '0;
            loss_q      <= '0;
            drst_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stb_q       <= stb_d;
            stg_q       <= stg_d;
            dom_q       <= dom_d;
            sys_rst_q   <= sys_rst_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            drst_prev_q <= drst_s;
        end
    end

    assign sys_rst       = sys_rst_q;
    assign rst_done      = done_q;
    assign dcm_fail      = fail_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_dcm_rst_seq.sv
// Directed bench for dcm_rst_seq with short timing parameters.
// Expected cycle numbers are hand-derived from the sequencer timing.
module tb_dcm_rst_seq;

    localparam int LSC = 10;
    localparam int STG = 4;
    localparam int ND  = 4;
    localparam int MR  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dcm_lock = 1'b0;
    logic          dcm_sta2 = 1'b0;
    logic          dcm_rst = 1'b0;
    logic [ND-1:0] sys_rst;
    logic          rst_done;
    logic          dcm_fail;
    logic [3:0]    retry_cnt;
    logic [7:0]    lock_loss_cnt;

    int n_run  = 0;
    int n_fail = 0;

    dcm_rst_seq #(
        .LOCK_STABLE_CYC (LSC),
        .STAGGER_CYC     (STG),
        .NUM_DOM         (ND),
        .MAX_RETRY       (MR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dcm_lock      (dcm_lock),
        .dcm_sta2      (dcm_sta2),
        .dcm_rst       (dcm_rst),
        .sys_rst       (sys_rst),
        .rst_done      (rst_done),
        .dcm_fail      (dcm_fail),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // leaves rst low just before edge 1
    task automatic do_reset();
        rst      = 1'b1;
        dcm_lock = 1'b0;
        dcm_sta2 = 1'b0;
        dcm_rst  = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic pulse_drst();
        dcm_rst = 1'b1;
        tick(1);
        dcm_rst = 1'b0;
        tick(4);
    endtask

    initial begin
        // reset values
        do_reset();
        check("rst_sys", 32'(sys_rst), 32'hF);
        check("rst_done", 32'(rst_done), 32'h0);
        check("rst_fail", 32'(dcm_fail), 32'h0);
        check("rst_retry", 32'(retry_cnt), 32'h0);
        check("rst_loss", 32'(lock_loss_cnt), 32'h0);

        // clean power-up sequence
        dcm_lock = 1'b1;
        tick(12);
        check("up_e12", 32'(sys_rst), 32'hF);
        tick(1);
        check("up_e13", 32'(sys_rst), 32'hE);
        tick(4);
        check("up_e17", 32'(sys_rst), 32'hC);
        tick(4);
        check("up_e21", 32'(sys_rst), 32'h8);
        tick(4);
        check("up_e25", 32'(sys_rst), 32'h0);
        check("up_e25_done", 32'(rst_done), 32'h0);
        tick(1);
        check("up_e26_done", 32'(rst_done), 32'h1);

        // lock loss in RUN, then full re-release
        dcm_lock = 1'b0;
        tick(3);
        check("loss_sys", 32'(sys_rst), 32'hF);
        check("loss_done", 32'(rst_done), 32'h0);
        check("loss_cnt", 32'(lock_loss_cnt), 32'h1);
        dcm_lock = 1'b1;
        tick(12);
        check("relk_e41", 32'(sys_rst), 32'hF);
        tick(1);
        check("relk_e42", 32'(sys_rst), 32'hE);
        tick(12);
        check("relk_e54", 32'(sys_rst), 32'h0);
        tick(1);
        check("relk_done", 32'(rst_done), 32'h1);

        // async reset from RUN
        #2;
        rst = 1'b1;
        #1;
        check("arst_run_sys", 32'(sys_rst), 32'hF);
        check("arst_run_loss", 32'(lock_loss_cnt), 32'h0);

        // lock glitch during STABLE restarts the full count
        do_reset();
        dcm_lock = 1'b1;
        tick(8);
        dcm_lock = 1'b0;
        tick(1);
        dcm_lock = 1'b1;
        tick(12);
        check("glit_e21", 32'(sys_rst), 32'hF);
        tick(1);
        check("glit_e22", 32'(sys_rst), 32'hE);
        check("glit_loss", 32'(lock_loss_cnt), 32'h0);

        // async reset from RELEASE
        tick(2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_rel_sys", 32'(sys_rst), 32'hF);
        check("arst_rel_done", 32'(rst_done), 32'h0);

        // retry cleared on RUN entry, ignored while in RUN
        do_reset();
        pulse_drst();
        check("rty_one", 32'(retry_cnt), 32'h1);
        dcm_lock = 1'b1;
        tick(27);
        check("rty_run_done", 32'(rst_done), 32'h1);
        check("rty_run_clr", 32'(retry_cnt), 32'h0);
        pulse_drst();
        check("rty_in_run", 32'(retry_cnt), 32'h0);
        check("rty_in_run_done", 32'(rst_done), 32'h1);

        // retries exhausted -> FAIL
        do_reset();
        pulse_drst();
        check("fail_r1", 32'(retry_cnt), 32'h1);
        pulse_drst();
        check("fail_r2", 32'(retry_cnt), 32'h2);
        check("fail_pre", 32'(dcm_fail), 32'h0);
        pulse_drst();
        check("fail_r3", 32'(retry_cnt), 32'h3);
        check("fail_flag", 32'(dcm_fail), 32'h1);
        dcm_lock = 1'b1;
        tick(30);
        check("fail_hold_sys", 32'(sys_rst), 32'hF);
        check("fail_hold_flag", 32'(dcm_fail), 32'h1);
        check("fail_hold_done", 32'(rst_done), 32'h0);

        // async reset from FAIL
        #2;
        rst = 1'b1;
        #1;
        check("arst_fail_flag", 32'(dcm_fail), 32'h0);
        check("arst_fail_rty", 32'(retry_cnt), 32'h0);
        check("arst_fail_sys", 32'(sys_rst), 32'hF);

        // lock-loss counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            dcm_lock = 1'b1;
            tick(14);
            dcm_lock = 1'b0;
            tick(4);
            if (i == 99) check("sat_100", 32'(lock_loss_cnt), 32'd100);
        end
        check("sat_255", 32'(lock_loss_cnt), 32'd255);
        check("sat_sys", 32'(sys_rst), 32'hF);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/dcm_rst_seq.md
DCM_RST_SEQ -- requirements
Module: dcm_rst_seq

Interface
REQ-001 SHALL provide parameter LOCK_STABLE_CYC, default 5000, the number of consecutive good-lock clk cycles required before release (100 us at 50 MHz).
REQ-002 SHALL provide parameter STAGGER_CYC, default 50, the number of clk cycles between successive domain reset releases.
REQ-003 SHALL provide parameter NUM_DOM, default 4, the number of downstream reset domains (range 1..8).
REQ-004 SHALL provide parameter MAX_RETRY, default 8, the number of DCM reset pulses tolerated before failure is declared (range 1..15).
REQ-005 SHALL have port clk, input, 1 bit: oscillator clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port dcm_lock, input, 1 bit, asynchronous: DCM locked.
REQ-008 SHALL have port dcm_sta2, input, 1 bit, asynchronous: DCM FX output stopped.
REQ-009 SHALL have port dcm_rst, input, 1 bit, asynchronous: DCM reset pulse observed from the DCM reset generator.
REQ-010 SHALL have port sys_rst, output, NUM_DOM bits: per-domain active-high reset; bit 0 releases first.
REQ-011 SHALL have port rst_done, output, 1 bit: all domain resets released.
REQ-012 SHALL have port dcm_fail, output, 1 bit: sticky failure flag.
REQ-013 SHALL have port retry_cnt, output, 4 bits: DCM reset pulses counted since last entry into RUN.
REQ-014 SHALL have port lock_loss_cnt, output, 8 bits: lock losses counted after release began; saturates at 255.

Function
REQ-015 SHALL synchronise dcm_lock, dcm_sta2 and dcm_rst through two flops each, giving 2 cycles of latency; "good" SHALL mean lock_s=1 and sta2_s=0.
REQ-016 SHALL implement FSM states WAIT_LOCK, STABLE, RELEASE, RUN and FAIL; reset state SHALL be WAIT_LOCK.
REQ-017 WAIT_LOCK SHALL go to STABLE on good and SHALL clear the stable counter.
REQ-018 STABLE SHALL increment the stable counter each good cycle and SHALL enter RELEASE in the cycle after the counter equals LOCK_STABLE_CYC-1; loss of good SHALL return to WAIT_LOCK with no count change.
REQ-019 RELEASE: sys_rst[0] SHALL be 0 from the first RELEASE cycle, and sys_rst[i] SHALL be 0 from STAGGER_CYC*i cycles after entry.
REQ-020 RELEASE SHALL enter RUN one cycle after sys_rst[NUM_DOM-1] clears, setting rst_done=1 and clearing retry_cnt.
REQ-021 Loss of good in RELEASE or RUN SHALL, in the next cycle, set all sys_rst=1 and rst_done=0, increment lock_loss_cnt (saturating) and enter WAIT_LOCK.
REQ-022 A rising edge of the synchronised dcm_rst in any state except RUN and FAIL SHALL increment retry_cnt.
REQ-023 When retry_cnt reaches MAX_RETRY, the FSM SHALL enter FAIL: all sys_rst=1, rst_done=0, dcm_fail=1, held until rst.
REQ-024 dcm_rst edges while in RUN SHALL be ignored.
REQ-025 Simultaneous events: FAIL entry SHALL take priority over all other transitions; loss of good SHALL take priority over a stable-counter terminal count or a stagger step in the same cycle.
REQ-026 All outputs SHALL be registered, and sys_rst bits SHALL be glitch-free.

Reset
REQ-027 On rst: sys_rst = all ones, rst_done=0, dcm_fail=0, retry_cnt=0, lock_loss_cnt=0, synchroniser flops=0, all counters=0, state=WAIT_LOCK.
REQ-028 rst asserted mid-operation, including in FAIL, SHALL take effect asynchronously; release SHALL be clean on the next clk edge.

Structure
REQ-029 A shared package dcm_pkg SHALL hold the FSM state enumeration and the default constants (LOCK_STABLE_CYC, STAGGER_CYC, MAX_RETRY).
REQ-030 A single sub-module sync_2ff (one-bit two-flop synchroniser, async reset) SHALL be instantiated three times; the stable and stagger counters SHALL be local.
REQ-031 Counter widths SHALL be derived from the parameters via $clog2.

Verification (bench params: LOCK_STABLE_CYC=10, STAGGER_CYC=4, NUM_DOM=4, MAX_RETRY=3)
REQ-032 Hold dcm_lock=1, dcm_sta2=0 from cycle 0 -> sys_rst[0] falls at cycle 13±1, bits 1/2/3 follow at +4/+8/+12, rst_done=1 one cycle after bit 3 clears.
REQ-033 Drop dcm_lock for 1 cycle at stable count 5 -> FSM returns to WAIT_LOCK, the full 10-cycle count restarts, lock_loss_cnt stays 0.
REQ-034 Drop dcm_lock in RUN -> all sys_rst=1 within 3 cycles, rst_done=0, lock_loss_cnt=1, full re-release sequence follows on relock.
REQ-035 Apply 3 dcm_rst pulses with lock never good -> retry_cnt steps 1,2,3, dcm_fail=1, then dcm_lock=1 has no effect until rst.
REQ-036 Apply 300 lock-loss/relock cycles -> lock_loss_cnt saturates at 255.
REQ-037 Assert rst in FAIL and in RELEASE -> all outputs return to reset values immediately, without waiting for a clk edge.
